sad_window_addr_gen: RTL and testbench
======================================

// Module: sad_window_addr_gen
// PURPOSE
//  Address generator upstream of the Memory stage for the SAD search. For every candidate
//  window position (X,Y) in a frame it emits the word address of each window element in
//  row-major order, tagged with (X,Y). These requests drive the data-memory read port; the
//  SAD1/SAD2 stages downstream consume the returned data.
// PARAMETERS
//  ADDR_W      32  address width (bits)
//  DIM_W       8   width of frame/window dimensions and X/Y coordinates
//  WORD_BYTES  4   byte stride between consecutive frame elements
// PORTS
//  Clk        in   1       single clock, rising edge
//  Reset      in   1       synchronous, active-high reset
//  Start      in   1       one-cycle pulse; sampled only in IDLE
//  BaseAddr   in   ADDR_W  byte address of frame element (0,0)
//  FrameW     in   DIM_W   frame width (elements)
//  FrameH     in   DIM_W   frame height (elements)
//  WinW       in   DIM_W   window width (elements)
//  WinH       in   DIM_W   window height (elements)
//  AddrReady  in   1       consumer accepts the current address
//  AddrValid  out  1       Address/X/Y/ElemLast/PosLast are valid
//  Address    out  ADDR_W  byte address of the current window element
//  X, Y       out  DIM_W   candidate position of the current element
//  ElemLast   out  1       last element of the current window
//  PosLast    out  1       last element of the last candidate position
//  Busy       out  1       high in SETUP and SCAN
//  Done       out  1       one-cycle pulse at end of scan
//  Err        out  1       set with Done when dimensions are illegal; held until next Start
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; all counters 0. Reset mid-scan aborts with no Done.
//  FSM: IDLE -Start-> SETUP -> SCAN -PosLast accepted-> DONE -> IDLE.
//   SETUP -> DONE with Err=1 if WinW==0, WinH==0, WinW>FrameW or WinH>FrameH.
//  SETUP (1 cycle): latch all inputs; compute RowSkip=(FrameW-WinW+1)*WORD_BYTES.
//   First AddrValid appears 2 cycles after the Start edge.
//  SCAN: element counters r in 0..WinH-1, c in 0..WinW-1; candidates Y in 0..FrameH-WinH,
//   X in 0..FrameW-WinW, raster order.
//   Address = BaseAddr + ((Y+r)*FrameW + (X+c))*WORD_BYTES, truncated to ADDR_W.
//   Address is updated incrementally, with no multiplier in the per-element path:
//    +WORD_BYTES within a row; +RowSkip at a row end; reload from a registered window-origin
//    address at a window end.
//  Handshake: a transfer occurs on a cycle with AddrValid && AddrReady. While AddrReady=0,
//   all outputs hold stable. AddrValid never drops in SCAN until PosLast is accepted.
//  ElemLast = (r==WinH-1 && c==WinW-1). PosLast = ElemLast && X==FrameW-WinW && Y==FrameH-WinH.
//  A Start asserted outside IDLE is ignored. WinW==FrameW is legal (one column of candidates).
//  DONE: Done=1 for exactly 1 cycle, AddrValid=0, then return to IDLE.
// CONFIGURATION
//  SAD_SERPENTINE_EN defined: on odd candidate rows, X runs from FrameW-WinW down to 0;
//   the element order within each window is unchanged; PosLast marks the true final position.
//  SAD_SERPENTINE_EN undefined: every candidate row scans X ascending (plain raster).
// STRUCTURE
//  Shared package sad_pkg: FSM state encoding (IDLE, SETUP, SCAN, DONE), DIM_W/ADDR_W
//   defaults, and the WORD_BYTES constant shared with the Memory and SAD stages.
//  One sub-module, sad_pos_counter: the nested c/r/X/Y counters with wrap flags and
//   serpentine direction; this module holds the FSM and the address arithmetic.
// TESTING
//  Frame 4x4, window 2x2, Base=0x100, Ready=1 -> 9 positions x 4 elems = 36 beats;
//   first addrs 0x100,0x104,0x110,0x114; last addr 0x13C with PosLast; Done 1 cycle later.
//  Same setup, Ready toggles 1/0 -> same 36-address sequence; outputs stable on Ready=0 cycles.
//  WinW=5 with FrameW=4 -> no AddrValid; Done and Err assert in the cycle after SETUP.
//  Frame 3x3, window 3x3 -> single position (0,0), 9 beats, the 9th has ElemLast=PosLast=1.
//  Reset asserted at beat 10 of the 4x4 case -> next cycle: IDLE, all outputs 0, no Done;
//   a new Start restarts from (0,0).
//  SAD_SERPENTINE_EN, 4x4 frame, 2x2 window -> X order 0,1,2 | 2,1,0 | 0,1,2.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search pipeline: FSM state encoding,
// default address/dimension widths and the element byte stride used by
// the address generator, the Memory stage and the SAD stages.
package sad_pkg;

    localparam int SAD_ADDR_W     = 32;
    localparam int SAD_DIM_W      = 8;
    localparam int SAD_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } sad_state_e;

endpackage

// File: rtl/sad_pos_counter.sv
// Nested element/candidate counters for the SAD window scan.
// c (column in window), r (row in window), X, Y (candidate position).
// Optional macro SAD_SERPENTINE_EN: odd candidate rows walk X downwards.
module sad_pos_counter
    import sad_pkg::*;
#(
    parameter int DIM_W = SAD_DIM_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             init_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] win_w_i,
    input  logic [DIM_W-1:0] win_h_i,
    input  logic [DIM_W-1:0] x_max_i,
    input  logic [DIM_W-1:0] y_max_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             c_last_o,
    output logic             elem_last_o,
    output logic             x_end_o,
    output logic             y_last_o,
    output logic             desc_o
);

    logic [DIM_W-1:0] c_q, c_d, r_q, r_d, x_q, x_d, y_q, y_d;
    logic             desc_q, desc_d;
    logic             r_last;

    assign c_last_o    = (c_q == win_w_i - DIM_W'(1));
    assign r_last      = (r_q == win_h_i - DIM_W'(1));
    assign elem_last_o = c_last_o && r_last;
    // End of a candidate row depends on which way X is currently walking.
    assign x_end_o     = desc_q ? (x_q == '0) : (x_q == x_max_i);
    assign y_last_o    = (y_q == y_max_i);
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign desc_o      = desc_q;

    // Next-state of the nested counters: c fastest, then r, then X, then Y.
    always_comb begin
        c_d    = c_q;
        r_d    = r_q;
        x_d    = x_q;
        y_d    = y_q;
        desc_d = desc_q;
        if (init_i) begin
            c_d    = '0;
            r_d    = '0;
            x_d    = '0;
            y_d    = '0;
            desc_d = 1'b0;
        end else if (adv_i) begin
            if (!c_last_o) begin
                c_d = c_q + DIM_W'(1);
            end else begin
                c_d = '0;
                if (!r_last) begin
                    r_d = r_q + DIM_W'(1);
                end else begin
                    r_d = '0;
                    if (!x_end_o) begin
                        x_d = desc_q ? (x_q - DIM_W'(1)) : (x_q + DIM_W'(1));
                    end else begin
                        if (!y_last_o) y_d = y_q + DIM_W'(1);
`ifdef SAD_SERPENTINE_EN
                        // X stays at the row end; the next row walks back.
                        desc_d = ~desc_q;
`else
                        x_d = '0;
`endif
                    end
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            c_q    <= '0;
            r_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            desc_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            r_q    <= r_d;
            x_q    <= x_d;
            y_q    <= y_d;
            desc_q <= desc_d;
        end
    end

endmodule

// File: rtl/sad_window_addr_gen.sv
// SAD window address generator: for each candidate position (X,Y) emits the
// byte address of every window element in row-major order over a
// valid/ready handshake. Addresses advance incrementally (no multiplier in
// the per-element path). Optional macro SAD_SERPENTINE_EN selects a
// serpentine candidate order (odd candidate rows scan X descending).
module sad_window_addr_gen
    import sad_pkg::*;
#(
    parameter int ADDR_W     = SAD_ADDR_W,
    parameter int DIM_W      = SAD_DIM_W,
    parameter int WORD_BYTES = SAD_WORD_BYTES
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [DIM_W-1:0]  frame_w_i,
    input  logic [DIM_W-1:0]  frame_h_i,
    input  logic [DIM_W-1:0]  win_w_i,
    input  logic [DIM_W-1:0]  win_h_i,
    input  logic              addr_ready_i,
    output logic              addr_valid_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DIM_W-1:0]  x_o,
    output logic [DIM_W-1:0]  y_o,
    output logic              elem_last_o,
    output logic              pos_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] WB = ADDR_W'(WORD_BYTES);

    sad_state_e        state_q;
    logic              valid_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q, org_q, row_skip_q, row_step_q;
    logic [DIM_W-1:0]  win_w_q, win_h_q, x_max_q, y_max_q;

    logic              adv, init, illegal;
    logic              c_last, elem_last, x_end, y_last, desc;
    logic              elem_last_v, pos_last_v;
    logic [ADDR_W-1:0] org_next;

    assign init    = (state_q == ST_SETUP);
    assign adv     = valid_q && addr_ready_i;
    assign illegal = (win_w_i == '0) || (win_h_i == '0) ||
                     (win_w_i > frame_w_i) || (win_h_i > frame_h_i);

    sad_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .init_i      (init),
        .adv_i       (adv),
        .win_w_i     (win_w_q),
        .win_h_i     (win_h_q),
        .x_max_i     (x_max_q),
        .y_max_i     (y_max_q),
        .x_o         (x_o),
        .y_o         (y_o),
        .c_last_o    (c_last),
        .elem_last_o (elem_last),
        .x_end_o     (x_end),
        .y_last_o    (y_last),
        .desc_o      (desc)
    );

    assign elem_last_v = valid_q && elem_last;
    assign pos_last_v  = elem_last_v && x_end && y_last;

    // Origin of the next candidate window: one element over along X, or one
    // candidate row down at a row end (row_step_q absorbs the X rewind).
    always_comb begin
        if (x_end)     org_next = org_q + row_step_q;
        else if (desc) org_next = org_q - WB;
        else           org_next = org_q + WB;
    end

    // Scan FSM with registered handshake/status outputs and address datapath.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            org_q      <= '0;
            row_skip_q <= '0;
            row_step_q <= '0;
            win_w_q    <= '0;
            win_h_q    <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    win_w_q    <= win_w_i;
                    win_h_q    <= win_h_i;
                    x_max_q    <= frame_w_i - win_w_i;
                    y_max_q    <= frame_h_i - win_h_i;
                    addr_q     <= base_addr_i;
                    org_q      <= base_addr_i;
                    row_skip_q <= (ADDR_W'(frame_w_i) - ADDR_W'(win_w_i) + ADDR_W'(1)) * WB;
`ifdef SAD_SERPENTINE_EN
                    row_step_q <= ADDR_W'(frame_w_i) * WB;
`else
                    row_step_q <= ADDR_W'(win_w_i) * WB;
`endif
                    if (illegal) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_SCAN;
                        valid_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (adv) begin
                        if (pos_last_v) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (elem_last) begin
                            addr_q <= org_next;
                            org_q  <= org_next;
                        end else if (c_last) begin
                            addr_q <= addr_q + row_skip_q;
                        end else begin
                            addr_q <= addr_q + WB;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign addr_valid_o = valid_q;
    assign address_o    = addr_q;
    assign elem_last_o  = elem_last_v;
    assign pos_last_o   = pos_last_v;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_sad_window_addr_gen.sv
// Directed self-checking bench for sad_window_addr_gen.
// Honours SAD_SERPENTINE_EN in its expected candidate order.
module tb_sad_window_addr_gen;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [31:0] base;
    logic [7:0]  fw, fh, ww, wh;
    logic        valid, el, pl, busy, done, err;
    logic [31:0] addr;
    logic [7:0]  x, y;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_addr[$];
    logic [7:0]  got_winx[$];

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        el;
        logic        pl;
    } beat_t;

    always #5 clk = ~clk;

    sad_window_addr_gen dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start),
        .base_addr_i  (base),
        .frame_w_i    (fw),
        .frame_h_i    (fh),
        .win_w_i      (ww),
        .win_h_i      (wh),
        .addr_ready_i (ready),
        .addr_valid_o (valid),
        .address_o    (addr),
        .x_o          (x),
        .y_o          (y),
        .elem_last_o  (el),
        .pos_last_o   (pl),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    wire beat_t cur = '{a: addr, x: x, y: y, el: el, pl: pl};

    // Full scan from IDLE; caller is aligned on a negedge.
    task automatic run_scan(input logic [7:0] f_w, f_h, w_w, w_h,
                            input logic [31:0] b, input bit toggle,
                            input int start_cyc, input string tag);
        beat_t exp_q[$];
        beat_t e, held_v;
        bit    serp, held;
        int    xm, ym, xx, beat, cyc, budget;
`ifdef SAD_SERPENTINE_EN
        serp = 1'b1;
`else
        serp = 1'b0;
`endif
        xm = int'(f_w) - int'(w_w);
        ym = int'(f_h) - int'(w_h);
        for (int yy = 0; yy <= ym; yy++)
            for (int xi = 0; xi <= xm; xi++) begin
                xx = (serp && yy[0]) ? xm - xi : xi;
                for (int r = 0; r < int'(w_h); r++)
                    for (int c = 0; c < int'(w_w); c++) begin
                        e.a  = b + 32'(((yy + r) * int'(f_w) + xx + c) * 4);
                        e.x  = 8'(xx);
                        e.y  = 8'(yy);
                        e.el = (r == int'(w_h) - 1) && (c == int'(w_w) - 1);
                        e.pl = e.el && (yy == ym) && (xi == xm);
                        exp_q.push_back(e);
                    end
            end
        got_addr.delete();
        got_winx.delete();
        fw = f_w; fh = f_h; ww = w_w; wh = w_h; base = b;
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, valid, done, err} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_setup: busy/valid/done/err=%b expected 1000", tag, {busy, valid, done, err});
        end
        @(negedge clk);
        beat = 0; cyc = 0; held = 1'b0; held_v = '0;
        budget = exp_q.size() * 3 + 10;
        while (beat < exp_q.size() && cyc < budget) begin
            ready = toggle ? (cyc % 2 == 0) : 1'b1;
            start = (cyc == start_cyc);
            if (held) begin
                checks++;
                if (cur !== held_v) begin
                    errors++;
                    $display("FAIL %s_hold beat %0d: got %h expected %h", tag, beat, cur, held_v);
                end
            end
            held = 1'b0;
            checks++;
            if (valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid beat %0d: valid=%b expected 1", tag, beat, valid);
            end else if (ready) begin
                checks++;
                if (cur !== exp_q[beat]) begin
                    errors++;
                    $display("FAIL %s_beat %0d: got a=%h x=%0d y=%0d el=%b pl=%b expected a=%h x=%0d y=%0d el=%b pl=%b",
                             tag, beat, addr, x, y, el, pl, exp_q[beat].a, exp_q[beat].x,
                             exp_q[beat].y, exp_q[beat].el, exp_q[beat].pl);
                end
                got_addr.push_back(addr);
                if (el) got_winx.push_back(x);
                beat++;
            end else begin
                held   = 1'b1;
                held_v = cur;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (beat < exp_q.size()) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d beats expected %0d", tag, beat, exp_q.size());
        end
        checks++;
        if ({done, valid, busy, err} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done: done/valid/busy/err=%b expected 1000", tag, {done, valid, busy, err});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b expected 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        base = 32'h0; fw = 8'd0; fh = 8'd0; ww = 8'd0; wh = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, addr, x, y, el, pl, busy, done, err} !== 54'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {valid, addr, x, y, el, pl, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: valid/busy/done=%b expected 000", {valid, busy, done});
        end
    endtask

    task automatic test_raster();
        run_scan(8'd4, 8'd4, 8'd2, 8'd2, 32'h100, 1'b0, -1, "raster");
        checks++;
        if (got_addr.size() != 36 || got_addr[0] !== 32'h100 || got_addr[1] !== 32'h104 ||
            got_addr[2] !== 32'h110 || got_addr[3] !== 32'h114 || got_addr[35] !== 32'h13C) begin
            errors++;
            $display("FAIL raster_addrs: n=%0d first=%h,%h,%h,%h last=%h expected 36 100,104,110,114 13c",
                     got_addr.size(), got_addr[0], got_addr[1], got_addr[2], got_addr[3],
                     got_addr[got_addr.size()-1]);
        end
    endtask

    // Ready toggling plus a stray Start mid-scan, which must be ignored.
    task automatic test_backpressure();
        run_scan(8'd4, 8'd4, 8'd2, 8'd2, 32'h100, 1'b1, 7, "bp");
        checks++;
        if (got_addr.size() != 36 || got_addr[2] !== 32'h110 || got_addr[35] !== 32'h13C) begin
            errors++;
            $display("FAIL bp_addrs: n=%0d a2=%h last=%h expected 36 110 13c",
                     got_addr.size(), got_addr[2], got_addr[got_addr.size()-1]);
        end
        @(negedge clk);
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_no_restart: busy/valid=%b expected 00", {busy, valid});
        end
    endtask

    task automatic illegal_case(input logic [7:0] f_w, f_h, w_w, w_h, input string tag);
        fw = f_w; fh = f_h; ww = w_w; wh = w_h; base = 32'h100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s_setup: busy/done/valid=%b expected 100", tag, {busy, done, valid});
        end
        @(negedge clk);
        checks++;
        if ({done, err, valid, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_err: done/err/valid/busy=%b expected 1100", tag, {done, err, valid, busy});
        end
        @(negedge clk);
        checks++;
        if ({done, err, valid} !== 3'b010) begin
            errors++;
            $display("FAIL %s_err_hold: done/err/valid=%b expected 010", tag, {done, err, valid});
        end
    endtask

    task automatic test_illegal();
        illegal_case(8'd4, 8'd4, 8'd5, 8'd2, "winw_gt");
        illegal_case(8'd4, 8'd4, 8'd2, 8'd0, "winh_zero");
        // A legal scan afterwards must clear Err at Start.
        run_scan(8'd3, 8'd2, 8'd2, 8'd2, 32'h40, 1'b0, -1, "after_err");
    endtask

    task automatic test_single();
        run_scan(8'd3, 8'd3, 8'd3, 8'd3, 32'h200, 1'b0, -1, "single");
        checks++;
        if (got_addr.size() != 9 || got_addr[8] !== 32'h220) begin
            errors++;
            $display("FAIL single_addrs: n=%0d last=%h expected 9 220", got_addr.size(),
                     got_addr[got_addr.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        fw = 8'd4; fh = 8'd4; ww = 8'd2; wh = 8'd2; base = 32'h100; ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n = 0; cyc = 0;
        while (n < 10 && cyc < 40) begin
            if (valid && ready) n++;
            @(negedge clk);
            cyc++;
        end
        if (n < 10) begin
            checks++; errors++;
            $display("FAIL rstmid_timeout: %0d beats expected 10", n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, addr, x, y, el, pl, busy, done, err} !== 54'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h expected 0", {valid, addr, x, y, el, pl, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_no_done: done/valid/busy=%b expected 000", {done, valid, busy});
        end
        run_scan(8'd4, 8'd4, 8'd2, 8'd2, 32'h100, 1'b0, -1, "restart");
    endtask

    task automatic test_order();
        logic [7:0] exp_x [9];
`ifdef SAD_SERPENTINE_EN
        exp_x = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2};
`else
        exp_x = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
`endif
        run_scan(8'd4, 8'd4, 8'd2, 8'd2, 32'h0, 1'b0, -1, "order");
        checks++;
        if (got_winx.size() != 9) begin
            errors++;
            $display("FAIL order_count: %0d windows expected 9", got_winx.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (got_winx[i] !== exp_x[i]) begin
                    errors++;
                    $display("FAIL order_x pos %0d: got %0d expected %0d", i, got_winx[i], exp_x[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_backpressure();
        test_illegal();
        test_single();
        test_reset_mid();
        test_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
